// File: rtl/mem_pkg.sv
// Shared types for the data-memory read-modify-write controller:
// funct3 encodings, controller states and byte-lane constants.
package mem_pkg;

    typedef enum logic [2:0] {
        MEM_B  = 3'b000,
        MEM_H  = 3'b001,
        MEM_W  = 3'b010,
        MEM_BU = 3'b100,
        MEM_HU = 3'b101
    } mem_funct3_e;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        LOAD_DATA   = 3'd1,
        STORE_MERGE = 3'd2,
        STORE_WRITE = 3'd3,
        ERROR_RESP  = 3'd4
    } mem_state_e;

    localparam logic [1:0] LANE_0 = 2'd0;
    localparam logic [1:0] LANE_1 = 2'd1;
    localparam logic [1:0] LANE_2 = 2'd2;
    localparam logic [1:0] LANE_3 = 2'd3;

endpackage

// File: rtl/memory_lane_align.sv
// Combinational lane alignment: load extract/extend and sub-word store merge.
// Ports: word_i (RAM word), lane_i, funct3_i, wdata_i -> load_o, merge_o.
module memory_lane_align
    import mem_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  lane_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_o,
    output logic [31:0] merge_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [4:0]  byte_off;
    logic [4:0]  half_off;

    always_comb begin
        byte_off = {lane_i, 3'b000};
        half_off = (lane_i == LANE_2) ? 5'd16 : 5'd0;
        byte_sel = word_i[byte_off +: 8];
        half_sel = word_i[half_off +: 16];

        case (funct3_i)
            MEM_B:   load_o = {{24{byte_sel[7]}}, byte_sel};
            MEM_H:   load_o = {{16{half_sel[15]}}, half_sel};
            MEM_BU:  load_o = {24'd0, byte_sel};
            MEM_HU:  load_o = {16'd0, half_sel};
            default: load_o = word_i;
        endcase

        merge_o = word_i;
        case (funct3_i)
            MEM_B:   merge_o[byte_off +: 8]  = wdata_i[7:0];
            MEM_H:   merge_o[half_off +: 16] = wdata_i[15:0];
            default: merge_o = word_i;
        endcase
    end

endmodule

// File: rtl/memory_rmw_controller.sv
// Data-memory controller: turns RISC-V loads/stores into word RAM accesses,
// with read-modify-write for SB/SH and extract/extend for sub-word loads.
// Ports: clock/reset, req_* request (ready in IDLE), resp_* one-cycle
// response, ram_read_* to RAM port A, ram_write_* to the RAM write port.
module memory_rmw_controller
    import mem_pkg::*;
#(
    parameter int RAM_A_WIDTH = 12
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_write,
    input  logic [2:0]             req_funct3,
    input  logic [31:0]            req_address,
    input  logic [31:0]            req_wdata,
    output logic                   resp_valid,
    output logic                   resp_error,
    output logic [31:0]            resp_rdata,
    output logic [RAM_A_WIDTH-1:0] ram_read_address,
    input  logic [31:0]            ram_read_data,
    output logic [RAM_A_WIDTH-1:0] ram_write_address,
    output logic [31:0]            ram_write_data,
    output logic                   ram_write_enable
);

    localparam int AW = RAM_A_WIDTH;

    mem_state_e    state_q, state_d;
    logic [AW-1:0] widx_q, widx_d;
    logic [1:0]    lane_q, lane_d;
    logic [2:0]    f3_q, f3_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          resp_valid_q, resp_valid_d;
    logic          resp_error_q, resp_error_d;
    logic          is_load_q, is_load_d;
    logic          we_q, we_d;
    logic [AW-1:0] wa_q, wa_d;
    logic [31:0]   wd_q, wd_d;

    logic          accept;
    logic          req_err;
    logic          bad_f3;
    logic [AW-1:0] req_widx;
    logic [31:0]   load_word;
    logic [31:0]   merge_word;

    assign req_widx  = req_address[AW+1:2];
    assign req_ready = (state_q == IDLE);
    assign accept    = req_valid && req_ready;

    always_comb begin
        case (req_funct3)
            MEM_B:   bad_f3 = 1'b0;
            MEM_H:   bad_f3 = req_address[0];
            MEM_W:   bad_f3 = |req_address[1:0];
            MEM_BU:  bad_f3 = req_write;
            MEM_HU:  bad_f3 = req_write | req_address[0];
            default: bad_f3 = 1'b1;
        endcase
        req_err = bad_f3 | (|req_address[31:AW+2]);
    end

    memory_lane_align u_align (
        .word_i   (ram_read_data),
        .lane_i   (lane_q),
        .funct3_i (f3_q),
        .wdata_i  (wdata_q),
        .load_o   (load_word),
        .merge_o  (merge_word)
    );

    // RAM data for the load arrives in LOAD_DATA, the one cycle is_load_q is set.
    assign resp_valid        = resp_valid_q;
    assign resp_error        = resp_error_q;
    assign resp_rdata        = is_load_q ? load_word : 32'd0;
    assign ram_read_address  = (state_q == IDLE) ? req_widx : widx_q;
    assign ram_write_address = wa_q;
    assign ram_write_data    = wd_q;
    assign ram_write_enable  = we_q;

    always_comb begin
        state_d      = state_q;
        widx_d       = widx_q;
        lane_d       = lane_q;
        f3_d         = f3_q;
        wdata_d      = wdata_q;
        resp_valid_d = 1'b0;
        resp_error_d = 1'b0;
        is_load_d    = 1'b0;
        we_d         = 1'b0;
        wa_d         = wa_q;
        wd_d         = wd_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    widx_d  = req_widx;
                    lane_d  = req_address[1:0];
                    f3_d    = req_funct3;
                    wdata_d = req_wdata;
                    if (req_err) begin
                        state_d      = ERROR_RESP;
                        resp_valid_d = 1'b1;
                        resp_error_d = 1'b1;
                    end else if (!req_write) begin
                        state_d      = LOAD_DATA;
                        resp_valid_d = 1'b1;
                        is_load_d    = 1'b1;
                    end else if (req_funct3 == MEM_W) begin
                        // Full word: no read needed, write next cycle.
                        state_d      = STORE_WRITE;
                        resp_valid_d = 1'b1;
                        we_d         = 1'b1;
                        wa_d         = req_widx;
                        wd_d         = req_wdata;
                    end else begin
                        state_d = STORE_MERGE;
                    end
                end
            end
            STORE_MERGE: begin
                state_d      = STORE_WRITE;
                resp_valid_d = 1'b1;
                we_d         = 1'b1;
                wa_d         = widx_q;
                wd_d         = merge_word;
            end
            LOAD_DATA, STORE_WRITE, ERROR_RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            widx_q       <= '0;
            lane_q       <= '0;
            f3_q         <= '0;
            wdata_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_error_q <= 1'b0;
            is_load_q    <= 1'b0;
            we_q         <= 1'b0;
            wa_q         <= '0;
            wd_q         <= '0;
        end else begin
            state_q      <= state_d;
            widx_q       <= widx_d;
            lane_q       <= lane_d;
            f3_q         <= f3_d;
            wdata_q      <= wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_error_q <= resp_error_d;
            is_load_q    <= is_load_d;
            we_q         <= we_d;
            wa_q         <= wa_d;
            wd_q         <= wd_d;
        end
    end

endmodule

// File: tb/tb_memory_rmw_controller.sv
// Self-checking bench for memory_rmw_controller: RAM model, reference model
// of transactions, per-cycle compare, directed literals and random traffic.
module tb_memory_rmw_controller;

    localparam int AW = 12;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [2:0]    req_funct3 = 3'd0;
    logic [31:0]   req_address = 32'd0;
    logic [31:0]   req_wdata = 32'd0;
    logic          resp_valid;
    logic          resp_error;
    logic [31:0]   resp_rdata;
    logic [AW-1:0] ram_read_address;
    logic [31:0]   ram_read_data;
    logic [AW-1:0] ram_write_address;
    logic [31:0]   ram_write_data;
    logic          ram_write_enable;

    always #5 clock = ~clock;

    memory_rmw_controller #(.RAM_A_WIDTH(AW)) dut (
        .clock             (clock),
        .reset             (reset),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_write         (req_write),
        .req_funct3        (req_funct3),
        .req_address       (req_address),
        .req_wdata         (req_wdata),
        .resp_valid        (resp_valid),
        .resp_error        (resp_error),
        .resp_rdata        (resp_rdata),
        .ram_read_address  (ram_read_address),
        .ram_read_data     (ram_read_data),
        .ram_write_address (ram_write_address),
        .ram_write_data    (ram_write_data),
        .ram_write_enable  (ram_write_enable)
    );

    // Synchronous-read RAM, read-before-write.
    bit [31:0] ram [0:(1<<AW)-1];
    always @(posedge clock) begin
        if (ram_write_enable) ram[ram_write_address] <= ram_write_data;
        ram_read_data <= ram[ram_read_address];
    end

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at t=%0t", name, got, exp, $time);
    endtask

    // ---------------- reference model ----------------
    bit [31:0] ref_mem [0:(1<<AW)-1];
    int        cyc = 0;
    int        resp_cyc = -1;
    int        we_cyc = -1;
    int        next_ready = 0;
    int        acc_count = 0;
    int        last_acc_cyc = 0;
    bit        e_err;
    bit [31:0] e_rd;
    int        p_wa;
    bit [31:0] p_wd;

    function automatic bit is_err(input bit w, input bit [2:0] f3,
                                  input bit [31:0] a);
        int sz;
        if (a >= (32'd1 << (AW + 2))) return 1'b1;
        case (f3)
            3'd0, 3'd4: sz = 1;
            3'd1, 3'd5: sz = 2;
            3'd2:       sz = 4;
            default:    return 1'b1;
        endcase
        if (w && f3 >= 3'd4) return 1'b1;
        return (a % sz) != 0;
    endfunction

    function automatic bit [31:0] load_val(input bit [31:0] word,
                                           input bit [2:0] f3, input int lane);
        bit [31:0] v;
        v = word >> (8 * lane);
        case (f3)
            3'd0: begin v = v & 32'hFF;   if (v >= 128)   v = v - 256;   end
            3'd1: begin v = v & 32'hFFFF; if (v >= 32768) v = v - 65536; end
            3'd4: v = v & 32'hFF;
            3'd5: v = v & 32'hFFFF;
            default: v = word;
        endcase
        return v;
    endfunction

    function automatic bit [31:0] merge_val(input bit [31:0] word,
                                            input bit [31:0] d,
                                            input bit [2:0] f3, input int lane);
        bit [31:0] mask;
        if (f3 == 3'd0) mask = 32'hFF << (8 * lane);
        else if (f3 == 3'd1) mask = 32'hFFFF << (8 * lane);
        else mask = 32'hFFFF_FFFF;
        return (word & ~mask) | ((d << (8 * lane)) & mask);
    endfunction

    always @(posedge clock) begin
        bit [31:0] a;
        int        idx;
        int        lane;
        int        dly;
        if (reset) begin
            resp_cyc   = -1;
            we_cyc     = -1;
            next_ready = 0;
        end else begin
            if (cyc == we_cyc) ref_mem[p_wa] = p_wd;
            if (req_valid && cyc >= next_ready) begin
                a    = req_address;
                idx  = int'(a[AW+1:2]);
                lane = int'(a[1:0]);
                acc_count++;
                last_acc_cyc = cyc;
                we_cyc = -1;
                resp_cyc = cyc + 1;
                e_err = 1'b0;
                e_rd  = 32'd0;
                if (is_err(req_write, req_funct3, a)) begin
                    e_err = 1'b1;
                end else if (!req_write) begin
                    e_rd = load_val(ref_mem[idx], req_funct3, lane);
                end else begin
                    dly      = (req_funct3 == 3'd2) ? 1 : 2;
                    resp_cyc = cyc + dly;
                    we_cyc   = cyc + dly;
                    p_wa     = idx;
                    p_wd     = merge_val(ref_mem[idx], req_wdata, req_funct3, lane);
                end
                next_ready = resp_cyc + 1;
            end
        end
        cyc = cyc + 1;
    end

    // ---------------- per-cycle compare and capture ----------------
    bit [31:0] last_rdata;
    bit        last_err;
    int        last_resp_cyc = 0;
    int        resp_count = 0;
    bit [31:0] last_wa;
    bit [31:0] last_wd;
    int        last_we_cyc = 0;
    int        we_count = 0;

    always @(negedge clock) begin
        bit exp_rv;
        bit exp_we;
        if (reset) begin
            check("rst_resp_valid", resp_valid, 0);
            check("rst_resp_error", resp_error, 0);
            check("rst_resp_rdata", resp_rdata, 0);
            check("rst_write_enable", ram_write_enable, 0);
            check("rst_req_ready", req_ready, 1);
        end else begin
            exp_rv = (cyc == resp_cyc);
            exp_we = (cyc == we_cyc);
            check("resp_valid", resp_valid, exp_rv);
            check("resp_error", resp_error, exp_rv && e_err);
            check("resp_rdata", resp_rdata, exp_rv ? e_rd : 32'd0);
            check("write_enable", ram_write_enable, exp_we);
            if (exp_we) begin
                check("write_address", ram_write_address, p_wa);
                check("write_data", ram_write_data, p_wd);
            end
            check("req_ready", req_ready, cyc >= next_ready);
            if (cyc >= next_ready)
                check("read_address", ram_read_address, req_address[AW+1:2]);
        end
        if (resp_valid) begin
            last_rdata    = resp_rdata;
            last_err      = resp_error;
            last_resp_cyc = cyc;
            resp_count++;
        end
        if (ram_write_enable) begin
            last_wa     = ram_write_address;
            last_wd     = ram_write_data;
            last_we_cyc = cyc;
            we_count++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic settle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic issue(input bit w, input bit [2:0] f3, input bit [31:0] a,
                         input bit [31:0] d, input bit rst_mid);
        int start;
        int n;
        start = acc_count;
        n = 0;
        req_valid   = 1'b1;
        req_write   = w;
        req_funct3  = f3;
        req_address = a;
        req_wdata   = d;
        do begin
            @(posedge clock);
            #1;
            n++;
        end while (acc_count == start && n < 8);
        if (acc_count == start) check("accept_timeout", 0, 1);
        if (rst_mid) reset = 1'b1;
        // Busy cycle: garbage that the controller must ignore.
        req_write   = 1'($urandom);
        req_funct3  = 3'($urandom);
        req_address = $urandom;
        req_wdata   = $urandom;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
    endtask

    initial begin
        int acc1;
        int wc;
        int rc;
        bit [2:0] f3s [0:7];
        bit [2:0] f3;
        bit [31:0] a;

        settle(3);
        reset = 1'b0;
        settle(1);

        for (int i = 0; i <= 16; i++) begin
            if (i == 5) issue(1, 3'd2, 32'(i * 4), 32'h8899AABC, 0);
            else if (i == 8) issue(1, 3'd2, 32'(i * 4), 32'h0, 0);
            else issue(1, 3'd2, 32'(i * 4), $urandom, 0);
        end

        issue(0, 3'd0, 32'h16, 0, 0);
        check("lb_data", last_rdata, 32'hFFFFFF99);
        check("lb_latency", last_resp_cyc - last_acc_cyc, 1);
        issue(0, 3'd4, 32'h16, 0, 0);
        check("lbu_data", last_rdata, 32'h00000099);

        issue(1, 3'd2, 32'h14, 32'h11223344, 0);
        wc = we_count;
        issue(1, 3'd0, 32'h15, 32'hFFFFFF5A, 0);
        settle(2);
        check("sb_write_count", we_count - wc, 1);
        check("sb_write_addr", last_wa, 5);
        check("sb_write_data", last_wd, 32'h11225A44);
        check("sb_write_latency", last_we_cyc - last_acc_cyc, 2);
        check("sb_resp_latency", last_resp_cyc - last_acc_cyc, 2);

        issue(1, 3'd1, 32'h22, 32'h1234BEEF, 0);
        settle(2);
        check("sh_write_addr", last_wa, 8);
        check("sh_write_data", last_wd, 32'hBEEF0000);
        issue(0, 3'd1, 32'h22, 0, 0);
        check("lh_data", last_rdata, 32'hFFFFBEEF);

        wc = we_count;
        issue(0, 3'd2, 32'h03, 0, 0);
        check("lw_misaligned_err", last_err, 1);
        issue(1, 3'd1, 32'h01, 32'hFFFF, 0);
        check("sh_misaligned_err", last_err, 1);
        check("sh_misaligned_latency", last_resp_cyc - last_acc_cyc, 1);
        issue(0, 3'd2, 32'd1 << (AW + 2), 0, 0);
        check("range_err", last_err, 1);
        check("range_err_rdata", last_rdata, 0);
        check("err_no_write", we_count - wc, 0);

        issue(1, 3'd2, 32'h40, 32'hDEADBEEF, 0);
        acc1 = last_acc_cyc;
        issue(0, 3'd2, 32'h40, 0, 0);
        check("b2b_data", last_rdata, 32'hDEADBEEF);
        check("b2b_spacing", last_acc_cyc - acc1, 2);

        wc = we_count;
        rc = resp_count;
        issue(1, 3'd0, 32'h15, 32'h77, 1);
        settle(1);
        reset = 1'b0;
        settle(2);
        check("rst_mid_no_write", we_count - wc, 0);
        check("rst_mid_no_resp", resp_count - rc, 0);
        check("rst_mid_ready", req_ready, 1);
        issue(0, 3'd2, 32'h14, 0, 0);
        check("rst_mid_word_kept", last_rdata, 32'h11225A44);

        f3s[0] = 3'd0; f3s[1] = 3'd1; f3s[2] = 3'd2; f3s[3] = 3'd4;
        f3s[4] = 3'd5; f3s[5] = 3'd3; f3s[6] = 3'd6; f3s[7] = 3'd7;
        for (int i = 0; i < 300; i++) begin
            f3 = ($urandom_range(0, 19) == 0) ? f3s[$urandom_range(5, 7)]
                                              : f3s[$urandom_range(0, 4)];
            a = 32'($urandom_range(0, 16) * 4);
            if ((f3 == 3'd1 || f3 == 3'd5) && $urandom_range(0, 3) != 0)
                a = a + 32'($urandom_range(0, 1) * 2);
            else if (f3 != 3'd2 || $urandom_range(0, 7) == 0)
                a = a + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 14) == 0)
                a = a | (32'd1 << $urandom_range(AW + 2, 31));
            issue(1'($urandom), f3, a, $urandom, 0);
            if ($urandom_range(0, 2) == 0) settle($urandom_range(1, 2));
        end

        settle(4);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/memory_rmw_controller.md
# memory_rmw_controller

Single-requester controller for the core's data memory: it owns the write port and read port A of the synchronous-read RAM. It turns RISC-V load and store requests (LB/LH/LW/LBU/LHU/SB/SH/SW) into word-wide RAM accesses, performing read-modify-write for sub-word stores and extract/extend for sub-word loads. It sits between the core's memory stage and the RAM, with one transaction in flight at a time.

## Interface
- RAM_A_WIDTH, default 12: RAM word-address width; the RAM holds 2**RAM_A_WIDTH 32-bit words.

- clock  in  1  single clock; all state changes on its rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request (IDLE only)
- req_write  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_address  in  32  byte address
- req_wdata  in  32  store data; the low byte or halfword is used for SB/SH
- resp_valid  out  1  one-cycle completion pulse
- resp_error  out  1  qualifies resp_valid: misaligned, out-of-range, or illegal funct3
- resp_rdata  out  32  load result, extended; 0 for stores and errors
- ram_read_address  out  RAM_A_WIDTH  to RAM read port A
- ram_read_data  in  32  from RAM port A, valid one cycle after the address
- ram_write_address  out  RAM_A_WIDTH
- ram_write_data  out  32
- ram_write_enable  out  1

## Operation
- States: IDLE, LOAD_DATA, STORE_MERGE, STORE_WRITE, ERROR_RESP.
- req_ready = (state == IDLE). A request is accepted on a cycle with req_valid && req_ready.
- Word index = req_address[RAM_A_WIDTH+1:2]. Byte lane = req_address[1:0].
- Error conditions:
  - Any of req_address[31:RAM_A_WIDTH+2] is nonzero.
  - H/HU with lane[0] = 1.
  - W with lane != 0.
  - funct3 is 011, 110 or 111, or a store uses funct3 100 or 101.
- On an accepted request, the first matching rule applies:
  - Error: go to ERROR_RESP. No RAM write occurs.
  - Load: go to LOAD_DATA.
  - SW: latch the address and data, then go to STORE_WRITE.
  - SB/SH: go to STORE_MERGE.
- In IDLE, ram_read_address is driven combinationally from the request's word index. In other states it is driven from the latched index.
- LOAD_DATA: select the lane from ram_read_data.
  - B/H are sign-extended; BU/HU are zero-extended.
  - Drive resp_valid=1 and resp_rdata with the result, then go to IDLE.
- STORE_MERGE: replace the addressed byte or halfword of ram_read_data with req_wdata[7:0] or req_wdata[15:0]. Register the merged word, then go to STORE_WRITE.
- STORE_WRITE: ram_write_enable=1 and resp_valid=1, then go to IDLE.
- ERROR_RESP: resp_valid=1 and resp_error=1, then go to IDLE.
- Request inputs are ignored outside IDLE. Only one transaction is in flight.

## Timing
- All outputs except req_ready and the IDLE-state ram_read_address are registered.
- Values during and after reset:
  - state=IDLE, so req_ready=1 once reset deasserts.
  - resp_valid=0, resp_error=0, resp_rdata=0.
  - ram_write_enable=0, ram_write_address=0, ram_write_data=0.
  - ram_read_address follows req_address in IDLE.
- Latency, with the request accepted at cycle N:
  - Load: resp_valid at N+1.
  - SW: write and resp_valid at N+1.
  - SB/SH: merge at N+1, write and resp_valid at N+2.
  - Error: resp_valid at N+1.
- resp_valid is exactly one cycle wide. Responses are 0 in all non-response cycles.
- Back-to-back: a new request can be accepted in the cycle after the response.
  - A load accepted right after a store to the same word reads the new data, because the write commits at the STORE_WRITE edge, before the load's read edge.
- Reset asserted mid-transaction:
  - ram_write_enable drops immediately. No partial write and no response.
  - The controller returns to IDLE.

## Structure
- Shared package mem_pkg holds:
  - funct3 enum: MEM_B, MEM_H, MEM_W, MEM_BU, MEM_HU.
  - State enum.
  - Lane constants.
- One combinational sub-module, memory_lane_align, with two functions:
  - Load extract/extend: word, lane, funct3 -> result.
  - Store merge: old word, new data, lane, funct3 -> merged word.

## Test plan
- Word 5 = 0x8899AABC, LB at address 0x16 -> resp_rdata = 0xFFFFFF99 at N+1. LBU at the same address -> 0x00000099.
- SB of 0x5A at 0x15 on word 5 = 0x11223344 -> no write at N+1. At N+2, write word 5 = 0x11225A44 with resp_valid.
- SH of 0xBEEF at 0x22 on word 8 = 0x00000000 -> word 8 = 0xBEEF0000. A following LH at 0x22 returns 0xFFFFBEEF.
- LW at 0x03, SH at 0x01, and address 1 << (RAM_A_WIDTH+2) -> resp_error=1 at N+1, and ram_write_enable never asserts.
- SW 0xDEADBEEF to 0x40, then LW 0x40 accepted in the next ready cycle -> returns 0xDEADBEEF. The two requests are accepted 2 cycles apart.
- Assert reset during STORE_MERGE of an SB -> no write occurs, resp_valid stays 0, and req_ready=1 after reset is released.
